// File: rtl/uart_rx_sampler_if.sv
// Serial-receive bundle: the line input plus the received-byte strobes and status.
interface uart_rx_sampler_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: synchronises rx, finds the start-bit centre, then samples
// each bit one bit period apart and strobes the byte or a framing error.
module uart_rx_sampler #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_rx_sampler_if.slave         sif
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } state_e;

  state_e          state_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= sif.rx;
      rx_s_q      <= rx_meta_q;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        StIdle: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s_q) state_q <= StStart;
        end

        StStart: begin
          if (clk_cnt_q == CntHalf) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            // Line back high at the start-bit centre: treat as a glitch.
            state_q   <= rx_s_q ? StIdle : StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (clk_cnt_q == CntLast) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end

        StStop: begin
          if (clk_cnt_q == CntLast) begin
            clk_cnt_q <= '0;
            data_q    <= shift_q;
            if (rx_s_q) begin
              valid_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StWaitIdle;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CntW'(1);
          end
        end

        // Hold off while the line is in break so it cannot decode as new frames.
        StWaitIdle: begin
          clk_cnt_q <= '0;
          if (rx_s_q) state_q <= StIdle;
        end

        default: begin
          state_q   <= StIdle;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
        end
      endcase
    end
  end

  assign sif.data      = data_q;
  assign sif.valid     = valid_q;
  assign sif.frame_err = frame_err_q;
  assign sif.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: the stimulus pushes the expected strobe
// per frame, and an independent monitor pops and checks each strobe the DUT emits.
module tb_uart_rx_sampler;

  localparam int unsigned CPB    = 16;
  localparam int unsigned HALF   = CPB / 2;
  localparam time         TCLK   = 10;
  localparam int unsigned EXPLAT = 2 + HALF + 9 * CPB;

  typedef struct {
    logic       err;
    logic [7:0] data;
    time        t0;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #(TCLK / 2) clk = ~clk;

  uart_rx_sampler_if sif ();

  uart_rx_sampler #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif.slave)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Every bit-level task starts and ends 2 ns after a rising edge.
  task automatic drive_bit(input logic b);
    sif.rx = b;
    repeat (CPB) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int unsigned n);
    sif.rx = 1'b1;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.err  = ~stop_bit;
    e.data = b;
    e.t0   = $time;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  // Monitor: every strobe must match the oldest expected frame, in kind, data and time.
  exp_t mon_e;
  time  mon_lat;
  initial begin
    forever begin
      @(negedge clk);
      if (sif.valid || sif.frame_err) begin
        if (sif.valid && sif.frame_err) begin
          total++;
          bad++;
          $display("FAIL strobe_exclusive actual=both required=one at %0t", $time);
        end
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe actual=valid:%0b,err:%0b,data:%0h required=none at %0t",
                   sif.valid, sif.frame_err, sif.data, $time);
        end else begin
          mon_e = sb.pop_front();
          check("strobe_err", {31'd0, sif.frame_err}, {31'd0, mon_e.err});
          check("strobe_valid", {31'd0, sif.valid}, {31'd0, ~mon_e.err});
          check("strobe_data", {24'd0, sif.data}, {24'd0, mon_e.data});
          mon_lat = $time - TCLK / 2 - mon_e.t0;
          total++;
          if (mon_lat < (EXPLAT - 1) * TCLK || mon_lat > (EXPLAT + 1) * TCLK) begin
            bad++;
            $display("FAIL strobe_latency actual=%0t required=%0d+-1 clk", mon_lat, EXPLAT);
          end
        end
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          fell_at;
    logic        saw_busy;
    logic [7:0]  rb;
    int unsigned gap;

    sif.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {24'd0, sif.data}, 32'h0);
    check("reset_valid", {31'd0, sif.valid}, 32'h0);
    check("reset_frame_err", {31'd0, sif.frame_err}, 32'h0);
    check("reset_busy", {31'd0, sif.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    idle(5);

    // Single byte
    send_frame(8'h55, 1'b1);
    idle(10);
    check("single_data", {24'd0, sif.data}, 32'h55);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);

    // False start: 3-clk glitch; busy must rise then drop by half-bit + sync + phase
    saw_busy = 1'b0;
    fell_at  = 0;
    sif.rx   = 1'b0;
    for (int i = 1; i <= int'(HALF) + 6; i++) begin
      @(posedge clk);
      #2;
      if (i == 3) sif.rx = 1'b1;
      if (sif.busy) saw_busy = 1'b1;
      else if (saw_busy && fell_at == 0) fell_at = i;
    end
    check("glitch_busy_rose", {31'd0, saw_busy}, 32'h1);
    total++;
    if (fell_at == 0 || fell_at > int'(HALF) + 3) begin
      bad++;
      $display("FAIL glitch_busy_fall actual=%0d required=1..%0d clk", fell_at, HALF + 3);
    end
    check("glitch_data_kept", {24'd0, sif.data}, 32'h3C);
    idle(5);

    // Framing error, then a break held low for 40 clk
    send_frame(8'hC3, 1'b0);
    sif.rx = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("break_busy", {31'd0, sif.busy}, 32'h1);
    check("break_data", {24'd0, sif.data}, 32'hC3);
    idle(4);
    check("break_released_busy", {31'd0, sif.busy}, 32'h0);

    // Recovery straight after the break
    send_frame(8'h81, 1'b1);
    idle(10);

    // Randomised good frames with random short gaps
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1);
      gap = $urandom_range(0, 4);
      if (gap != 0) idle(gap);
    end
    send_frame(8'h5A, 1'b1);
    idle(5);

    for (int w = 0; w < 400 && sb.size() != 0; w++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 32'h0);

    // Reset mid-DATA while sending 8'hA5: outputs clear at once, no strobe afterwards
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("midframe_busy", {31'd0, sif.busy}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_data", {24'd0, sif.data}, 32'h0);
    check("async_reset_valid", {31'd0, sif.valid}, 32'h0);
    check("async_reset_frame_err", {31'd0, sif.frame_err}, 32'h0);
    check("async_reset_busy", {31'd0, sif.busy}, 32'h0);
    sif.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    check("post_reset_busy", {31'd0, sif.busy}, 32'h0);
    check("post_reset_data", {24'd0, sif.data}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
